// File: rtl/pet_input_conditioner_pkg.sv
// ============================================================================
// Module : pmo_input_pkg
// Brief  : Shared constants, touch FSM encoding and helpers for the input
//          conditioner.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pmo_input_pkg;

    // Direction bit positions inside the debounced {up, down, left, right} vector
    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;
    localparam int IDX_TOUCH = 4;
    localparam int IDX_BTN   = 5;
    localparam int N_INPUTS  = 6;

    localparam int DEF_TICK_DIV      = 100000;
    localparam int DEF_DB_TICKS      = 20;
    localparam int DEF_PET_TICKS     = 800;
    localparam int DEF_EXPECT_TICKS  = 3000;
    localparam int DEF_REPEAT_DELAY  = 400;
    localparam int DEF_REPEAT_PERIOD = 150;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_HOLD = 2'd1,
        T_PET  = 2'd2
    } touch_state_t;

    function automatic logic is_one_hot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pet_input_conditioner_if.sv
// ============================================================================
// Module : pet_input_conditioner_if
// Brief  : Raw joystick/touch inputs and conditioned event outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pet_input_conditioner_if;
    logic jstk_up_raw;
    logic jstk_down_raw;
    logic jstk_left_raw;
    logic jstk_right_raw;
    logic jstk_btn_raw;
    logic touch_raw;
    logic up;
    logic down;
    logic left;
    logic right;
    logic pressed;
    logic touched;
    logic petting;
    logic expecting;
    logic awaking;

    modport master (
        output jstk_up_raw, jstk_down_raw, jstk_left_raw, jstk_right_raw,
        output jstk_btn_raw, touch_raw,
        input  up, down, left, right, pressed, touched, petting, expecting, awaking
    );

    modport slave (
        input  jstk_up_raw, jstk_down_raw, jstk_left_raw, jstk_right_raw,
        input  jstk_btn_raw, touch_raw,
        output up, down, left, right, pressed, touched, petting, expecting, awaking
    );
endinterface

`default_nettype wire

// File: rtl/pet_input_conditioner_debounce.sv
// ============================================================================
// Module : input_debounce
// Brief  : 2-FF synchroniser followed by a tick-sampled stable counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module input_debounce #(
    parameter int DB_TICKS = 20
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic tick,
    input  wire logic raw,
    output logic      level,
    output logic      flip
);
    localparam int            CW     = $clog2(DB_TICKS + 1);
    localparam logic [CW-1:0] C_LAST = CW'(DB_TICKS - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;

    // flip is high in the cycle whose closing edge toggles the level
    assign flip  = tick && (r_sync[1] != r_level) && (r_cnt == C_LAST);
    assign level = r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], raw};
            if (tick) begin
                if (r_sync[1] == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == C_LAST) begin
                    r_level <= ~r_level;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/pet_input_conditioner.sv
// ============================================================================
// Module : pet_input_conditioner
// Brief  : Debounces joystick/touch inputs and produces clean controller events.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pet_input_conditioner
    import pmo_input_pkg::*;
#(
    parameter int TICK_DIV      = DEF_TICK_DIV,
    parameter int DB_TICKS      = DEF_DB_TICKS,
    parameter int PET_TICKS     = DEF_PET_TICKS,
    parameter int EXPECT_TICKS  = DEF_EXPECT_TICKS,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    pet_input_conditioner_if.slave bus
);
    localparam int            TW            = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] C_TICK_LAST   = TW'(TICK_DIV - 1);
    localparam int            RW            = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RW-1:0] C_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] C_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam int            PW            = $clog2(PET_TICKS + 1);
    localparam logic [PW-1:0] C_PET_LAST    = PW'(PET_TICKS - 1);
    localparam int            EW            = $clog2(EXPECT_TICKS + 1);
    localparam logic [EW-1:0] C_EXPECT      = EW'(EXPECT_TICKS);
    localparam logic [EW-1:0] C_EXP_ONE     = EW'(1);

    logic [TW-1:0]       r_tick_cnt;
    logic                w_tick;
    logic [N_INPUTS-1:0] w_raw, w_lvl, w_flip, w_rise;
    logic [3:0]          w_dir_now, w_dir_next, r_dir_pulse;
    logic [RW-1:0]       r_rep_cnt;
    logic                r_rep_run, r_pressed, r_awaking;
    logic                w_touch_fall, w_tap, w_pet_rise;
    touch_state_t        r_state;
    logic [PW-1:0]       r_hold_cnt;
    logic [EW-1:0]       r_exp_cnt;
    logic                r_petting, r_expecting;

    assign w_tick = (r_tick_cnt == C_TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= '0;
        else             r_tick_cnt <= r_tick_cnt + TW'(1);
    end

    always_comb begin
        w_raw            = '0;
        w_raw[DIR_UP]    = bus.jstk_up_raw;
        w_raw[DIR_DOWN]  = bus.jstk_down_raw;
        w_raw[DIR_LEFT]  = bus.jstk_left_raw;
        w_raw[DIR_RIGHT] = bus.jstk_right_raw;
        w_raw[IDX_TOUCH] = bus.touch_raw;
        w_raw[IDX_BTN]   = bus.jstk_btn_raw;
    end

    for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_db
        input_debounce #(.DB_TICKS(DB_TICKS)) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (w_tick),
            .raw   (w_raw[gi]),
            .level (w_lvl[gi]),
            .flip  (w_flip[gi])
        );
    end

    // Events act on the edge where a level flips, so pulses land one cycle later
    assign w_rise       = w_flip & ~w_lvl;
    assign w_touch_fall = w_flip[IDX_TOUCH] & w_lvl[IDX_TOUCH];
    assign w_dir_now    = w_lvl[3:0];
    assign w_dir_next   = w_lvl[3:0] ^ w_flip[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir_pulse <= '0;
            r_rep_cnt   <= '0;
            r_rep_run   <= 1'b0;
            r_pressed   <= 1'b0;
            r_awaking   <= 1'b0;
        end else begin
            r_pressed   <= w_rise[IDX_BTN];
            r_awaking   <= |w_rise;
            r_dir_pulse <= '0;
            if (!is_one_hot4(w_dir_next)) begin
                r_rep_cnt <= '0;
                r_rep_run <= 1'b0;
            end else if (w_dir_next != w_dir_now) begin
                r_dir_pulse <= w_dir_next;
                r_rep_cnt   <= '0;
                r_rep_run   <= 1'b0;
            end else if (w_tick) begin
                if ((!r_rep_run && r_rep_cnt == C_DELAY_LAST) ||
                    ( r_rep_run && r_rep_cnt == C_PERIOD_LAST)) begin
                    r_dir_pulse <= w_dir_now;
                    r_rep_cnt   <= '0;
                    r_rep_run   <= 1'b1;
                end else begin
                    r_rep_cnt <= r_rep_cnt + RW'(1);
                end
            end
        end
    end

    assign w_tap      = (r_state == T_HOLD) && w_touch_fall;
    assign w_pet_rise = (r_state == T_HOLD) && !w_touch_fall && w_tick &&
                        (r_hold_cnt == C_PET_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= T_IDLE;
            r_hold_cnt  <= '0;
            r_petting   <= 1'b0;
            r_exp_cnt   <= '0;
            r_expecting <= 1'b0;
        end else begin
            case (r_state)
                T_IDLE: if (w_rise[IDX_TOUCH]) begin
                    r_state    <= T_HOLD;
                    r_hold_cnt <= '0;
                end
                T_HOLD: if (w_tap) begin
                    r_state <= T_IDLE;
                end else if (w_pet_rise) begin
                    r_state    <= T_PET;
                    r_petting  <= 1'b1;
                    r_hold_cnt <= '0;
                end else if (w_tick) begin
                    r_hold_cnt <= r_hold_cnt + PW'(1);
                end
                T_PET: if (w_touch_fall) begin
                    r_state   <= T_IDLE;
                    r_petting <= 1'b0;
                end
                default: r_state <= T_IDLE;
            endcase

            // A press in the same cycle as a tap wins and closes the window
            if (w_rise[IDX_BTN] || w_pet_rise) begin
                r_expecting <= 1'b0;
                r_exp_cnt   <= '0;
            end else if (w_tap) begin
                r_expecting <= 1'b1;
                r_exp_cnt   <= C_EXPECT;
            end else if (w_tick && r_expecting) begin
                if (r_exp_cnt <= C_EXP_ONE) begin
                    r_expecting <= 1'b0;
                    r_exp_cnt   <= '0;
                end else begin
                    r_exp_cnt <= r_exp_cnt - EW'(1);
                end
            end
        end
    end

    assign bus.up        = r_dir_pulse[DIR_UP];
    assign bus.down      = r_dir_pulse[DIR_DOWN];
    assign bus.left      = r_dir_pulse[DIR_LEFT];
    assign bus.right     = r_dir_pulse[DIR_RIGHT];
    assign bus.pressed   = r_pressed;
    assign bus.touched   = w_lvl[IDX_TOUCH];
    assign bus.petting   = r_petting;
    assign bus.expecting = r_expecting;
    assign bus.awaking   = r_awaking;
endmodule

`default_nettype wire

// File: tb/tb_pet_input_conditioner.sv
// ============================================================================
// Module : tb_pet_input_conditioner
// Brief  : Directed self-checking bench for pet_input_conditioner.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pet_input_conditioner;
    localparam int TD = 4;

    localparam int M_UP = 0, M_DOWN = 1, M_LEFT = 2, M_RIGHT = 3;
    localparam int M_PRESS = 4, M_WAKE = 5, M_EXP = 6, M_PET = 7;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    pet_input_conditioner_if bus ();

    pet_input_conditioner #(
        .TICK_DIV(TD), .DB_TICKS(3), .PET_TICKS(10), .EXPECT_TICKS(8),
        .REPEAT_DELAY(6), .REPEAT_PERIOD(3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mon;
    logic [7:0] mon_q = '0;
    int         hi_cnt[8];
    int         rise_cnt[8];
    int         multi_cnt = 0;
    int         base_hi[8];
    int         base_rise[8];

    assign mon = {bus.petting, bus.expecting, bus.awaking, bus.pressed,
                  bus.right, bus.left, bus.down, bus.up};

    always @(negedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (mon[k])               hi_cnt[k]   <= hi_cnt[k] + 1;
            if (mon[k] && !mon_q[k])  rise_cnt[k] <= rise_cnt[k] + 1;
        end
        if ($countones(mon[3:0]) > 1) multi_cnt <= multi_cnt + 1;
        mon_q <= mon;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        cycles(n * TD);
    endtask

    task automatic snap();
        for (int k = 0; k < 8; k++) begin
            base_hi[k]   = hi_cnt[k];
            base_rise[k] = rise_cnt[k];
        end
    endtask

    function automatic int dr(input int k);
        return rise_cnt[k] - base_rise[k];
    endfunction

    function automatic int dh(input int k);
        return hi_cnt[k] - base_hi[k];
    endfunction

    function automatic int all_outs();
        return int'({bus.up, bus.down, bus.left, bus.right, bus.pressed,
                     bus.touched, bus.petting, bus.expecting, bus.awaking});
    endfunction

    initial begin
        rst_n = 1'b0;
        bus.jstk_up_raw = 0; bus.jstk_down_raw = 0; bus.jstk_left_raw = 0;
        bus.jstk_right_raw = 0; bus.jstk_btn_raw = 0; bus.touch_raw = 0;
        cycles(3);
        check("reset_outputs", all_outs(), 0);
        rst_n = 1'b1;
        ticks(2);

        // Button: one-tick glitch, then a real press
        snap();
        bus.jstk_btn_raw = 1; ticks(1);
        bus.jstk_btn_raw = 0; ticks(4);
        check("glitch_pressed", dr(M_PRESS), 0);
        check("glitch_awaking", dr(M_WAKE), 0);
        bus.jstk_btn_raw = 1; ticks(5);
        bus.jstk_btn_raw = 0; ticks(5);
        check("press_count", dr(M_PRESS), 1);
        check("press_width", dh(M_PRESS), 1);
        check("press_awaking_count", dr(M_WAKE), 1);
        check("press_awaking_width", dh(M_WAKE), 1);

        // Right held 20 ticks: initial + delay + 4 periodic
        snap();
        bus.jstk_right_raw = 1; ticks(20);
        bus.jstk_right_raw = 0; ticks(5);
        check("right_pulses", dr(M_RIGHT), 6);
        check("right_width", dh(M_RIGHT), 6);
        check("right_others", dr(M_UP) + dr(M_DOWN) + dr(M_LEFT), 0);
        check("right_awaking", dr(M_WAKE), 1);

        // Up+left together, then left released
        snap();
        bus.jstk_up_raw = 1; bus.jstk_left_raw = 1; ticks(12);
        check("combo_quiet", dr(M_UP) + dr(M_DOWN) + dr(M_LEFT) + dr(M_RIGHT), 0);
        check("combo_awaking_single", dh(M_WAKE), 1);
        bus.jstk_left_raw = 0; ticks(4);
        bus.jstk_up_raw = 0; ticks(5);
        check("combo_up_pulse", dr(M_UP), 1);
        check("combo_other_dirs", dr(M_DOWN) + dr(M_LEFT) + dr(M_RIGHT), 0);

        // Single tap: 8-tick expecting window
        snap();
        bus.touch_raw = 1; ticks(4);
        check("tap_touched_high", int'(bus.touched), 1);
        check("tap_expecting_during", int'(bus.expecting), 0);
        ticks(1);
        bus.touch_raw = 0; ticks(4);
        check("tap_touched_low", int'(bus.touched), 0);
        check("tap_expecting_set", int'(bus.expecting), 1);
        ticks(8);
        check("tap_expecting_expired", int'(bus.expecting), 0);
        check("tap_window_cycles", dh(M_EXP), 8 * TD);
        check("tap_no_petting", dh(M_PET), 0);
        check("tap_awaking", dr(M_WAKE), 1);

        // Second tap 6 ticks into the window reloads it
        snap();
        bus.touch_raw = 1; ticks(5);
        bus.touch_raw = 0; ticks(3);
        bus.touch_raw = 1; ticks(3);
        bus.touch_raw = 0; ticks(7);
        check("retap_still_expecting", int'(bus.expecting), 1);
        ticks(6);
        check("retap_expired", int'(bus.expecting), 0);
        check("retap_window_cycles", dh(M_EXP), 14 * TD);
        check("retap_awaking", dr(M_WAKE), 2);

        // Tap and press land on the same edge: press wins
        snap();
        bus.touch_raw = 1; ticks(5);
        bus.touch_raw = 0; bus.jstk_btn_raw = 1; ticks(5);
        bus.jstk_btn_raw = 0; ticks(10);
        check("tie_expecting_cycles", dh(M_EXP), 0);
        check("tie_pressed", dr(M_PRESS), 1);

        // Press 3 ticks into the window closes it
        snap();
        bus.touch_raw = 1; ticks(5);
        bus.touch_raw = 0; ticks(3);
        bus.jstk_btn_raw = 1; ticks(5);
        bus.jstk_btn_raw = 0; ticks(8);
        check("press_cut_cycles", dh(M_EXP), 3 * TD);
        check("press_cut_pressed", dr(M_PRESS), 1);

        // Long touch: petting after 10 debounced ticks, clears on release
        snap();
        bus.touch_raw = 1; ticks(11);
        check("pet_not_yet", int'(bus.petting), 0);
        ticks(3);
        check("pet_asserted", int'(bus.petting), 1);
        ticks(1);
        bus.touch_raw = 0; ticks(1);
        check("pet_held_until_fall", int'(bus.petting), 1);
        ticks(4);
        check("pet_released", int'(bus.petting), 0);
        check("pet_touched_low", int'(bus.touched), 0);
        ticks(10);
        check("pet_cycles", dh(M_PET), 5 * TD);
        check("pet_no_expecting", dh(M_EXP), 0);

        // Asynchronous reset mid-petting with right held
        bus.touch_raw = 1; bus.jstk_right_raw = 1; ticks(14);
        check("pre_reset_petting", int'(bus.petting), 1);
        rst_n = 1'b0;
        #2;
        check("async_reset_outputs", all_outs(), 0);
        cycles(2);
        snap();
        rst_n = 1'b1;
        ticks(5);
        check("post_reset_right", dr(M_RIGHT), 1);
        check("post_reset_awaking", dr(M_WAKE), 1);
        check("post_reset_touched", int'(bus.touched), 1);
        check("post_reset_petting", int'(bus.petting), 0);
        bus.touch_raw = 0; bus.jstk_right_raw = 0; ticks(6);

        check("one_direction_at_a_time", multi_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
